// File: rtl/write_test_pkg.sv
`default_nettype none
// ============================================================================
// Module      : write_test_pkg
// Description : Pattern modes, default LFSR taps and generator helper
//               functions for the write-stream checker.
// Revision    : 1.0 - initial release
// ============================================================================
package write_test_pkg;

    typedef enum logic [1:0] {
        PAT_FIXED = 2'd0,
        PAT_INC   = 2'd1,
        PAT_LFSR  = 2'd2,
        PAT_WALK  = 2'd3
    } pattern_mode_e;

    localparam logic [31:0] DEFAULT_LFSR_TAPS = 32'h8020_0003;

    // Helpers work on 64-bit containers; the caller passes its real width.
    function automatic logic [63:0] width_mask(input int w);
        if (w >= 64) return {64{1'b1}};
        return (64'd1 << w) - 64'd1;
    endfunction

    // LFSR and walking-one would lock up on an all-zero state.
    function automatic logic [63:0] seed_rule(input pattern_mode_e mode,
                                              input logic [63:0] seed);
        if ((mode == PAT_LFSR || mode == PAT_WALK) && seed == 64'd0)
            return 64'd1;
        return seed;
    endfunction

    function automatic logic [63:0] next_pattern(input pattern_mode_e mode,
                                                 input logic [63:0] e,
                                                 input logic [63:0] taps,
                                                 input int w);
        logic [63:0] m;
        logic [63:0] r;
        m = width_mask(w);
        case (mode)
            PAT_INC:  r = e + 64'd1;
            PAT_LFSR: r = {e[62:0], ^(e & taps & m)};
            PAT_WALK: r = (e << 1) | ((e >> (w - 1)) & 64'd1);
            default:  r = e;
        endcase
        return r & m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with registered flags, registered read
//               data plus one-cycle valid, and a drain-hold test input.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 1024
) (
    input  logic              okClk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] din,
    input  logic              drain_hold,
    output logic [DATA_W-1:0] dout,
    output logic              valid,
    output logic              full
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic [AW:0]       count_next;
    logic              empty;
    logic              wr;
    logic              rd;

    // Both strobes come from flags registered at the previous edge.
    assign wr = wr_en && !full;
    assign rd = !empty && !drain_hold;

    always_comb begin
        count_next = count + {{AW{1'b0}}, wr} - {{AW{1'b0}}, rd};
    end

    always_ff @(posedge okClk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
            valid  <= 1'b0;
        end else begin
            if (wr) wr_ptr <= wr_ptr + 1'b1;
            if (rd) rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
            empty <= (count_next == '0);
            full  <= (count_next == (AW+1)'(FIFO_DEPTH));
            valid <= rd;
        end
    end

    always_ff @(posedge okClk) begin
        if (wr && !reset) mem[wr_ptr] <= din;
        if (rd) dout <= mem[rd_ptr];
    end

endmodule
`default_nettype wire

// File: rtl/write_stream_checker.sv
`default_nettype none
// ============================================================================
// Module      : write_stream_checker
// Description : Buffers pipe-in words, drains and checks them against a
//               selectable pattern; reports timer, counters and first error.
// Revision    : 1.0 - initial release
// ============================================================================
module write_stream_checker
    import write_test_pkg::*;
#(
    parameter int                DATA_W     = 32,
    parameter int                FIFO_DEPTH = 1024,
    parameter int                CNT_W      = 64,
    parameter logic [DATA_W-1:0] LFSR_TAPS  = DATA_W'(DEFAULT_LFSR_TAPS)
) (
    input  logic              okClk,
    input  logic              reset,
    input  logic              start_timer,
    input  logic              stop_timer,
    input  logic              reset_pattern,
    input  logic [1:0]        pattern_mode,
    input  logic [DATA_W-1:0] pattern_seed,
    input  logic              pipe_in_write,
    input  logic [DATA_W-1:0] pipe_in_data,
    output logic              fifo_full,
    output logic              fifo_overflow,
    output logic              timer_on,
    output logic [CNT_W-1:0]  clk_counts,
    output logic [31:0]       word_count,
    output logic [31:0]       error_count,
    output logic              first_err_valid,
    output logic [31:0]       first_err_index,
    output logic [DATA_W-1:0] first_err_data
);

    logic              drain_hold_tie;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    pattern_mode_e     mode;
    pattern_mode_e     mode_in;
    logic [DATA_W-1:0] expected;
    logic [DATA_W-1:0] expected_next;
    logic [DATA_W-1:0] seed_value;
    logic              mismatch;

    // Held low in production; only a test harness overrides it.
    assign drain_hold_tie = 1'b0;

    sync_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .okClk      (okClk),
        .reset      (reset),
        .wr_en      (pipe_in_write),
        .din        (pipe_in_data),
        .drain_hold (drain_hold_tie),
        .dout       (rd_data),
        .valid      (rd_valid),
        .full       (fifo_full)
    );

    assign mode_in       = pattern_mode_e'(pattern_mode);
    assign seed_value    = DATA_W'(seed_rule(mode_in, 64'(pattern_seed)));
    assign expected_next = DATA_W'(next_pattern(mode, 64'(expected),
                                                64'(LFSR_TAPS), DATA_W));
    assign mismatch      = rd_valid && (rd_data != expected);

    always_ff @(posedge okClk) begin
        if (reset) begin
            mode            <= mode_in;
            expected        <= seed_value;
            word_count      <= '0;
            error_count     <= '0;
            first_err_valid <= 1'b0;
            first_err_index <= '0;
            first_err_data  <= '0;
            fifo_overflow   <= 1'b0;
        end else begin
            if (pipe_in_write && fifo_full) fifo_overflow <= 1'b1;
            if (mismatch) begin
                if (error_count != 32'hFFFF_FFFF)
                    error_count <= error_count + 32'd1;
                if (!first_err_valid) begin
                    first_err_valid <= 1'b1;
                    first_err_index <= word_count;
                    first_err_data  <= rd_data;
                end
            end
            if (rd_valid) begin
                word_count <= word_count + 32'd1;
                expected   <= expected_next;
            end
            // The word above was already checked against the old value.
            if (reset_pattern) begin
                mode       <= mode_in;
                expected   <= seed_value;
                word_count <= '0;
            end
        end
    end

    always_ff @(posedge okClk) begin
        if (reset) begin
            timer_on   <= 1'b0;
            clk_counts <= '0;
        end else begin
            if (stop_timer)       timer_on <= 1'b0;
            else if (start_timer) timer_on <= 1'b1;
            if (timer_on || start_timer)
                clk_counts <= clk_counts + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_write_stream_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_write_stream_checker
// Description : Directed self-checking bench for write_stream_checker.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_write_stream_checker;

    logic        okClk = 1'b0;
    logic        reset;
    logic        start_timer;
    logic        stop_timer;
    logic        reset_pattern;
    logic [1:0]  pattern_mode;
    logic [31:0] pattern_seed;
    logic        pipe_in_write;
    logic [31:0] pipe_in_data;
    logic        fifo_full;
    logic        fifo_overflow;
    logic        timer_on;
    logic [63:0] clk_counts;
    logic [31:0] word_count;
    logic [31:0] error_count;
    logic        first_err_valid;
    logic [31:0] first_err_index;
    logic [31:0] first_err_data;

    int checks   = 0;
    int failures = 0;

    always #5 okClk = ~okClk;

    write_stream_checker dut (
        .okClk           (okClk),
        .reset           (reset),
        .start_timer     (start_timer),
        .stop_timer      (stop_timer),
        .reset_pattern   (reset_pattern),
        .pattern_mode    (pattern_mode),
        .pattern_seed    (pattern_seed),
        .pipe_in_write   (pipe_in_write),
        .pipe_in_data    (pipe_in_data),
        .fifo_full       (fifo_full),
        .fifo_overflow   (fifo_overflow),
        .timer_on        (timer_on),
        .clk_counts      (clk_counts),
        .word_count      (word_count),
        .error_count     (error_count),
        .first_err_valid (first_err_valid),
        .first_err_index (first_err_index),
        .first_err_data  (first_err_data)
    );

    task automatic tick();
        @(posedge okClk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input logic [1:0] mode, input logic [31:0] seed);
        pattern_mode = mode;
        pattern_seed = seed;
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    logic [31:0] lfsr_words [64];
    logic [31:0] e;
    logic [31:0] walk;
    int          exp_err;
    int          exp_first;

    initial begin
        reset = 1'b0; start_timer = 1'b0; stop_timer = 1'b0; reset_pattern = 1'b0;
        pattern_mode = 2'd0; pattern_seed = '0; pipe_in_write = 1'b0; pipe_in_data = '0;
        tick();

        // Reset state
        do_reset(2'd1, 32'h10);
        check("rst_word_count", 64'(word_count), 64'd0);
        check("rst_error_count", 64'(error_count), 64'd0);
        check("rst_first_err_valid", 64'(first_err_valid), 64'd0);
        check("rst_first_err_index", 64'(first_err_index), 64'd0);
        check("rst_first_err_data", 64'(first_err_data), 64'd0);
        check("rst_fifo_full", 64'(fifo_full), 64'd0);
        check("rst_fifo_overflow", 64'(fifo_overflow), 64'd0);
        check("rst_timer_on", 64'(timer_on), 64'd0);
        check("rst_clk_counts", clk_counts, 64'd0);

        // Increment mode, 1024 back-to-back correct words
        for (int i = 0; i < 1024; i++) begin
            pipe_in_write = 1'b1;
            pipe_in_data  = 32'h10 + 32'(i);
            tick();
        end
        pipe_in_write = 1'b0;
        tick(); tick();
        check("inc_word_count_t3", 64'(word_count), 64'd1024);
        check("inc_error_count", 64'(error_count), 64'd0);
        check("inc_first_err_valid", 64'(first_err_valid), 64'd0);

        // reset_pattern to seed 0; word 5 corrupted
        pattern_mode = 2'd1; pattern_seed = 32'h0;
        reset_pattern = 1'b1;
        tick();
        reset_pattern = 1'b0;
        check("rp_word_count", 64'(word_count), 64'd0);
        for (int i = 0; i < 10; i++) begin
            pipe_in_write = 1'b1;
            pipe_in_data  = (i == 5) ? 32'hDEAD : 32'(i);
            tick();
        end
        pipe_in_write = 1'b0;
        repeat (4) tick();
        check("err_error_count", 64'(error_count), 64'd1);
        check("err_first_valid", 64'(first_err_valid), 64'd1);
        check("err_first_index", 64'(first_err_index), 64'd5);
        check("err_first_data", 64'(first_err_data), 64'hDEAD);
        check("err_word_count", 64'(word_count), 64'd10);

        // LFSR mode from zero seed (substituted by 1)
        e = 32'd1;
        for (int i = 0; i < 64; i++) begin
            lfsr_words[i] = e;
            e = {e[30:0], ^(e & 32'h8020_0003)};
        end
        do_reset(2'd2, 32'd0);
        for (int i = 0; i < 64; i++) begin
            pipe_in_write = 1'b1;
            pipe_in_data  = lfsr_words[i];
            tick();
        end
        pipe_in_write = 1'b0;
        repeat (4) tick();
        check("lfsr_word_count", 64'(word_count), 64'd64);
        check("lfsr_error_count", 64'(error_count), 64'd0);

        // Same stream checked as walking-one
        exp_err = 0; exp_first = -1; walk = 32'd1;
        for (int i = 0; i < 64; i++) begin
            if (lfsr_words[i] != walk) begin
                exp_err++;
                if (exp_first < 0) exp_first = i;
            end
            walk = {walk[30:0], walk[31]};
        end
        do_reset(2'd3, 32'd0);
        for (int i = 0; i < 64; i++) begin
            pipe_in_write = 1'b1;
            pipe_in_data  = lfsr_words[i];
            tick();
        end
        pipe_in_write = 1'b0;
        repeat (4) tick();
        check("walk_error_count", 64'(error_count), 64'(exp_err));
        check("walk_first_index", 64'(first_err_index), 64'(exp_first));
        check("walk_first_data", 64'(first_err_data), 64'(lfsr_words[exp_first]));

        // Drain held: fill, overflow, then release
        do_reset(2'd1, 32'd0);
        force dut.drain_hold_tie = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            pipe_in_write = 1'b1;
            pipe_in_data  = 32'(i);
            tick();
        end
        pipe_in_write = 1'b0;
        check("hold_full", 64'(fifo_full), 64'd1);
        check("hold_no_overflow_yet", 64'(fifo_overflow), 64'd0);
        pipe_in_write = 1'b1;
        pipe_in_data  = 32'hFFFF;
        tick();
        pipe_in_write = 1'b0;
        check("hold_overflow", 64'(fifo_overflow), 64'd1);
        check("hold_word_count", 64'(word_count), 64'd0);
        force dut.drain_hold_tie = 1'b0;
        repeat (1030) tick();
        release dut.drain_hold_tie;
        check("hold_drained_words", 64'(word_count), 64'd1024);
        check("hold_drained_errors", 64'(error_count), 64'd0);
        check("hold_full_cleared", 64'(fifo_full), 64'd0);

        // Timer: start edge plus 99 more edges up to and including stop
        do_reset(2'd0, 32'd0);
        start_timer = 1'b1;
        tick();
        start_timer = 1'b0;
        check("timer_on_started", 64'(timer_on), 64'd1);
        check("timer_first_count", clk_counts, 64'd1);
        repeat (98) tick();
        stop_timer = 1'b1;
        tick();
        stop_timer = 1'b0;
        check("timer_count_100", clk_counts, 64'd100);
        check("timer_off", 64'(timer_on), 64'd0);
        repeat (3) tick();
        check("timer_held", clk_counts, 64'd100);

        do_reset(2'd0, 32'd0);
        start_timer = 1'b1; stop_timer = 1'b1;
        tick();
        start_timer = 1'b0; stop_timer = 1'b0;
        repeat (2) tick();
        check("timer_both_count", clk_counts, 64'd1);
        check("timer_both_off", 64'(timer_on), 64'd0);

        // Reset one cycle after a mismatching write, with a write pending
        do_reset(2'd1, 32'd0);
        pipe_in_write = 1'b1;
        pipe_in_data  = 32'hBAD;
        tick();
        reset = 1'b1;
        pipe_in_data = 32'hBAD2;
        tick();
        reset = 1'b0;
        pipe_in_write = 1'b0;
        check("midrst_error_count", 64'(error_count), 64'd0);
        check("midrst_word_count", 64'(word_count), 64'd0);
        check("midrst_first_valid", 64'(first_err_valid), 64'd0);
        check("midrst_fifo_full", 64'(fifo_full), 64'd0);
        repeat (5) tick();
        check("midrst_flushed_words", 64'(word_count), 64'd0);
        check("midrst_flushed_errors", 64'(error_count), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
